memstage_hs: RTL and testbench
==============================

MEMSTAGE_HS -- requirements
Module: memstage_hs

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width (>= 3).
REQ-002 SHALL have parameter TIMEOUT, default 255: max cycles waited for i_mem_ack (1..65535).
REQ-003 SHALL fix data width at 32 bits, with 4 byte lanes.
REQ-004 SHALL have port i_clk  in  1  clock; all logic on the rising edge.
REQ-005 SHALL have port i_reset  in  1  reset; one clock, synchronous, active-high.
REQ-006 SHALL have port i_valid  in  1  MEM-stage instruction carries a load/store.
REQ-007 SHALL have port i_lsu_op  in  4  {is_store, funct3}; encodings in the package.
REQ-008 SHALL have port i_addr  in  ADDR_W  byte address (ALU result).
REQ-009 SHALL have port i_wdata  in  32  store data (rs2).
REQ-010 SHALL have port o_stall  out  1  hold IF..MEM and insert bubble into WB.
REQ-011 SHALL have port o_done  out  1  one-cycle pulse: access retired.
REQ-012 SHALL have port o_ld_data  out  32  extended load result, valid with o_done.
REQ-013 SHALL have port o_misalign  out  1  one-cycle misaligned-access flag.
REQ-014 SHALL have port o_timeout  out  1  one-cycle pulse: memory failed to ack.
REQ-015 SHALL have memory-side ports o_mem_req, o_mem_we (1), o_mem_addr (ADDR_W, word-aligned), o_mem_wdata (32), o_mem_be (4), i_mem_ack (1), i_mem_rdata (32).

Function
REQ-016 SHALL implement FSM IDLE/WAIT/RESP.
REQ-017 IDLE: on i_valid with an aligned address, SHALL capture op, addr[1:0], word address, lane-shifted wdata and be into registers, then go to WAIT.
REQ-018 WAIT: o_mem_req=1, with all o_mem_* held stable; i_mem_ack SHALL move the FSM to RESP and latch i_mem_rdata on loads.
REQ-019 RESP: o_done=1 for one cycle, then IDLE; back-to-back accesses are allowed, so a new i_valid is accepted in the following IDLE cycle.
REQ-020 o_stall = (IDLE & i_valid & ~trap) | WAIT; it is 0 in RESP.
REQ-021 Minimum latency: accept at cycle N, ack at N+1, o_done at N+2.
REQ-022 Store lanes: SB gives be=0001<<a[1:0] with wdata byte replicated; SH gives be=0011<<{a[1],0}; SW gives be=1111.
REQ-023 Loads: LB/LH sign-extend and LBU/LHU zero-extend the lane selected by captured addr[1:0]; LW passes the word through.
REQ-024 A 16-bit counter SHALL clear on entering WAIT and increment each WAIT cycle without ack; reaching TIMEOUT SHALL pulse o_timeout and o_done, force o_ld_data=0, and return to IDLE without a RESP cycle.
REQ-025 Ack and timeout in the same cycle: ack wins.
REQ-026 An i_mem_ack seen outside WAIT SHALL be ignored.
REQ-027 Unused opcodes (funct3 011/110/111): the op is accepted as a no-op, with no o_mem_req, and o_done follows one cycle later.

Reset
REQ-028 i_reset SHALL force IDLE and clear counter and captured registers; o_stall, o_done, o_mem_req, o_misalign and o_timeout are 0 after the edge, and o_ld_data=0.
REQ-029 A reset during WAIT SHALL drop o_mem_req on that edge and emit no o_done.

Configuration
REQ-030 The feature SHALL be selected by macro MEMSTAGE_MISALIGN_TRAP_EN.
REQ-031 With MEMSTAGE_MISALIGN_TRAP_EN defined, a misaligned op (halfword with a[0]=1; word with a[1:0]!=0) SHALL never issue; o_misalign and o_done pulse in the cycle after i_valid, with o_stall=0.
REQ-032 Without MEMSTAGE_MISALIGN_TRAP_EN, the offending low address bits SHALL be forced to 0, the access proceeds normally, and o_misalign is tied 0.

Structure
REQ-033 Package memstage_pkg SHALL hold LSU opcode localparams (LB=0000, LH=0001, LW=0010, LBU=0100, LHU=0101, SB=1000, SH=1001, SW=1010) and the FSM state enum.
REQ-034 Lane logic SHALL live in sub-module memstage_lane (combinational: be/wdata shift and load extension); FSM, counter and registers stay in memstage_hs.

Verification
REQ-035 SW at 0x100 with data 0xDEADBEEF, ack one cycle after req -> o_mem_be=1111, o_mem_addr=0x100, o_done at N+2, stall high for 2 cycles.
REQ-036 Memory word 0x80F0_7F01 at 0x200; LB from 0x203 -> 0xFFFFFF80; LBU -> 0x00000080; LH from 0x202 -> 0xFFFF80F0.
REQ-037 SB of 0xAB at 0x305 -> be=0010, wdata=0xABABABAB, addr=0x304.
REQ-038 TIMEOUT=4 with ack never given -> o_timeout and o_done 5 cycles after accept, o_ld_data=0, FSM back in IDLE.
REQ-039 With trap enabled, LW at 0x102 -> o_misalign=1, no o_mem_req; with trap disabled -> access goes to 0x100, o_misalign=0.
REQ-040 i_reset asserted during WAIT -> o_mem_req=0 next cycle, no o_done; a subsequent LW completes normally.

Source files
------------

// File: rtl/memstage_pkg.sv
// Shared definitions for the MEM-stage load/store unit:
// LSU opcodes ({is_store, funct3}) and the FSM state encoding.
package memstage_pkg;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_known(input logic [3:0] op);
    return (op == OP_LB)  || (op == OP_LH)  ||
           (op == OP_LW)  || (op == OP_LBU) ||
           (op == OP_LHU) || (op == OP_SB)  ||
           (op == OP_SH)  || (op == OP_SW);
  endfunction

endpackage

// File: rtl/memstage_lane.sv
// Byte-lane logic: store byte-enable / data replication and
// load lane selection with sign or zero extension.
module memstage_lane
  import memstage_pkg::*;
(
  input  logic [3:0]  i_st_op,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_ld_op,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld
);

  logic [31:0] w_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_sh   = i_rdata >> {i_ld_off, 3'b000};
  assign w_byte = w_sh[7:0];
  assign w_half = w_sh[15:0];

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'd0;
    unique case (1'b1)
      (i_st_op == OP_SB): begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      (i_st_op == OP_SH): begin
        o_be    = 4'b0011 << {i_st_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      (i_st_op == OP_SW): begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ld = 32'd0;
    unique case (1'b1)
      (i_ld_op == OP_LB):  o_ld = {{24{w_byte[7]}}, w_byte};
      (i_ld_op == OP_LBU): o_ld = {24'd0, w_byte};
      (i_ld_op == OP_LH):  o_ld = {{16{w_half[15]}}, w_half};
      (i_ld_op == OP_LHU): o_ld = {16'd0, w_half};
      (i_ld_op == OP_LW):  o_ld = i_rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/memstage_hs.sv
// MEM-stage load/store unit with req/ack memory handshake and timeout.
// Define MEMSTAGE_MISALIGN_TRAP_EN to trap misaligned accesses.
module memstage_hs
  import memstage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [3:0]        i_lsu_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [31:0]       o_ld_data,
  output logic              o_misalign,
  output logic              o_timeout,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata
);

  state_e r_state, w_next;

  logic [3:0]        r_op;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_we;
  logic              r_isld;
  logic [31:0]       r_rdata;
  logic [15:0]       r_cnt;
  logic              r_tmo;

  logic        w_known;
  logic        w_trap;
  logic        w_hit;
  logic        w_accept;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld;

  assign w_known  = op_known(i_lsu_op);
  assign w_accept = (r_state == ST_IDLE) && i_valid;
  assign w_hit    = ({1'b0, r_cnt} + 17'd1) == 17'(TIMEOUT);

  // Low address bits the access width cannot use are dropped.
  always_comb begin
    w_off = i_addr[1:0];
    case (i_lsu_op[1:0])
      2'b01:   w_off = {i_addr[1], 1'b0};
      2'b10:   w_off = 2'b00;
      default: w_off = i_addr[1:0];
    endcase
  end

`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_trap = w_known & (i_addr[1:0] != w_off);
  always_ff @(posedge i_clk) begin
    if (i_reset)       r_mis <= 1'b0;
    else if (w_accept) r_mis <= w_trap;
  end
  assign o_misalign = (r_state == ST_RESP) & r_mis;
`else
  assign w_trap     = 1'b0;
  assign o_misalign = 1'b0;
`endif

  memstage_lane u_lane (
    .i_st_op  (i_lsu_op),
    .i_st_off (w_off),
    .i_wdata  (i_wdata),
    .i_ld_op  (r_op),
    .i_ld_off (r_off),
    .i_rdata  (r_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_ld     (w_ld)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:
        if (i_valid)
          w_next = (w_trap || !w_known) ? ST_RESP : ST_WAIT;
      ST_WAIT:
        if (i_mem_ack)  w_next = ST_RESP;
        else if (w_hit) w_next = ST_IDLE;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_op    <= 4'd0;
      r_off   <= 2'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_we    <= 1'b0;
      r_isld  <= 1'b0;
      r_rdata <= 32'd0;
      r_cnt   <= 16'd0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tmo   <= (r_state == ST_WAIT) && !i_mem_ack && w_hit;
      if (w_accept) begin
        r_op    <= i_lsu_op;
        r_off   <= w_off;
        r_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_we    <= i_lsu_op[3];
        r_isld  <= w_known && !i_lsu_op[3] && !w_trap;
        r_rdata <= 32'd0;
        r_cnt   <= 16'd0;
      end else if (r_state == ST_WAIT) begin
        if (i_mem_ack) begin
          if (r_isld) r_rdata <= i_mem_rdata;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign o_stall     = (w_accept && !w_trap) || (r_state == ST_WAIT);
  assign o_done      = (r_state == ST_RESP) || r_tmo;
  assign o_timeout   = r_tmo;
  assign o_ld_data   = ((r_state == ST_RESP) && r_isld) ? w_ld : 32'd0;
  assign o_mem_req   = (r_state == ST_WAIT);
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_be    = r_be;

endmodule

// File: tb/tb_memstage_hs.sv
// Self-checking bench for memstage_hs: directed scenarios plus
// randomized accesses against an arithmetic reference model.
module tb_memstage_hs;
  import memstage_pkg::*;

  localparam int TMO = 4;
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic [3:0]  i_lsu_op = 4'd0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_wdata = 32'd0;
  logic        o_stall, o_done, o_misalign, o_timeout;
  logic [31:0] o_ld_data;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;

  int checks = 0;
  int failures = 0;

  memstage_hs #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid),
    .i_lsu_op(i_lsu_op), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_done(o_done), .o_ld_data(o_ld_data),
    .o_misalign(o_misalign), .o_timeout(o_timeout),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_be(o_mem_be), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  // Reference model
  function automatic bit m_known(input logic [3:0] op);
    return op == OP_LB || op == OP_LH || op == OP_LW ||
           op == OP_LBU || op == OP_LHU || op == OP_SB ||
           op == OP_SH || op == OP_SW;
  endfunction

  function automatic bit m_mis(input logic [3:0] op,
                               input logic [31:0] a);
    if (op == OP_LH || op == OP_LHU || op == OP_SH)
      return (a % 2) != 0;
    if (op == OP_LW || op == OP_SW)
      return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op,
                                      input logic [31:0] a);
    int unsigned v;
    v = 0;
    if (op == OP_SB) v = 1 << (a % 4);
    if (op == OP_SH) v = 3 << (a & 2);
    if (op == OP_SW) v = 15;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [3:0] op,
                                       input logic [31:0] d);
    if (op == OP_SB) return (d & 255) * 32'h0101_0101;
    if (op == OP_SH) return (d & 65535) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [3:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * (a % 4))) & 255;
    h = (w >> (8 * (a & 2))) & 65535;
    if (op == OP_LB)  return (b >= 128) ? b - 256 : b;
    if (op == OP_LBU) return b;
    if (op == OP_LH)  return (h >= 32768) ? h - 65536 : h;
    if (op == OP_LHU) return h;
    return w;
  endfunction

  // One access from its accept cycle to the idle cycle after o_done.
  task automatic run_access(input logic [3:0] op,
                            input logic [31:0] a,
                            input logic [31:0] d,
                            input logic [31:0] mw,
                            input int lat);
    int kind;
    logic st;
    kind = !m_known(op) ? 1 : (TRAP && m_mis(op, a)) ? 2 : 0;
    st = op[3];
    checks++;
    if (o_done !== 1'b0) begin
      failures++;
      $display("FAIL idle_done got=%b exp=0", o_done);
    end
    i_valid = 1'b1; i_lsu_op = op; i_addr = a; i_wdata = d;
    #1;
    checks++;
    if (o_stall !== (kind != 2)) begin
      failures++;
      $display("FAIL accept_stall op=%h got=%b exp=%b",
               op, o_stall, kind != 2);
    end
    step();
    i_valid = 1'b0; i_addr = $urandom; i_wdata = $urandom;
    #1;
    if (kind != 0) begin
      checks++;
      if ({o_done, o_mem_req, o_misalign, o_stall, o_ld_data} !==
          {1'b1, 1'b0, kind == 2, 1'b0, 32'd0}) begin
        failures++;
        $display("FAIL noissue op=%h a=%h got=%b%b%b%b %h",
                 op, a, o_done, o_mem_req, o_misalign, o_stall,
                 o_ld_data);
      end
      step();
      return;
    end
    for (int w = 0; w <= lat; w++) begin
      checks++;
      if ({o_mem_req, o_mem_we, o_mem_addr} !==
          {1'b1, st, a & ~32'h3}) begin
        failures++;
        $display("FAIL req_bus op=%h got=%b %b %h exp we=%b addr=%h",
                 op, o_mem_req, o_mem_we, o_mem_addr, st, a & ~32'h3);
      end
      if (st) begin
        checks++;
        if ({o_mem_be, o_mem_wdata} !== {m_be(op, a), m_wd(op, d)}) begin
          failures++;
          $display("FAIL store_lanes op=%h a=%h got=%b %h exp=%b %h",
                   op, a, o_mem_be, o_mem_wdata, m_be(op, a),
                   m_wd(op, d));
        end
      end
      i_mem_ack = (w == lat);
      i_mem_rdata = (w == lat) ? mw : $urandom;
      #1;
      checks++;
      if ({o_stall, o_done, o_timeout} !== 3'b100) begin
        failures++;
        $display("FAIL wait_flags got=%b%b%b exp=100",
                 o_stall, o_done, o_timeout);
      end
      step();
    end
    i_mem_ack = 1'b0;
    #1;
    checks++;
    if ({o_done, o_stall, o_timeout, o_misalign, o_mem_req} !==
        5'b10000) begin
      failures++;
      $display("FAIL resp_flags got=%b%b%b%b%b exp=10000",
               o_done, o_stall, o_timeout, o_misalign, o_mem_req);
    end
    if (!st) begin
      checks++;
      if (o_ld_data !== m_ld(op, a, mw)) begin
        failures++;
        $display("FAIL ld_data op=%h a=%h got=%h exp=%h",
                 op, a, o_ld_data, m_ld(op, a, mw));
      end
    end
    step();
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step(); step();
    checks++;
    if ({o_stall, o_done, o_mem_req, o_misalign, o_timeout,
         o_ld_data, o_mem_addr, o_mem_be} !== 73'd0) begin
      failures++;
      $display("FAIL reset_state got=%b%b%b%b%b %h %h %b",
               o_stall, o_done, o_mem_req, o_misalign, o_timeout,
               o_ld_data, o_mem_addr, o_mem_be);
    end
    i_reset = 1'b0;
    step();
  endtask

  task automatic test_store();
    run_access(OP_SW, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    run_access(OP_SB, 32'h305, 32'h0000_00AB, 32'h0, 0);
    run_access(OP_SH, 32'h30E, 32'h1234_5678, 32'h0, 1);
  endtask

  task automatic test_loads();
    run_access(OP_LB,  32'h203, 32'h0, 32'h80F0_7F01, 0);
    run_access(OP_LBU, 32'h203, 32'h0, 32'h80F0_7F01, 0);
    run_access(OP_LH,  32'h202, 32'h0, 32'h80F0_7F01, 0);
    run_access(OP_LHU, 32'h202, 32'h0, 32'h80F0_7F01, 2);
    run_access(OP_LB,  32'h200, 32'h0, 32'h80F0_7F01, 0);
    run_access(OP_LW,  32'h200, 32'h0, 32'h80F0_7F01, TMO - 1);
  endtask

  task automatic test_timeout();
    i_valid = 1'b1; i_lsu_op = OP_LW; i_addr = 32'h400;
    step();
    i_valid = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      #1;
      checks++;
      if ({o_mem_req, o_stall, o_done, o_timeout} !== 4'b1100) begin
        failures++;
        $display("FAIL tmo_wait k=%0d got=%b%b%b%b exp=1100", k,
                 o_mem_req, o_stall, o_done, o_timeout);
      end
      step();
    end
    #1;
    checks++;
    if ({o_timeout, o_done, o_mem_req, o_stall, o_ld_data} !==
        {4'b1100, 32'd0}) begin
      failures++;
      $display("FAIL tmo_pulse got=%b%b%b%b %h exp=1100 0",
               o_timeout, o_done, o_mem_req, o_stall, o_ld_data);
    end
    step();
    checks++;
    if ({o_timeout, o_done, o_mem_req} !== 3'b000) begin
      failures++;
      $display("FAIL tmo_after got=%b%b%b exp=000",
               o_timeout, o_done, o_mem_req);
    end
    run_access(OP_LW, 32'h404, 32'h0, 32'hCAFE_F00D, 0);
  endtask

  task automatic test_misalign();
    run_access(OP_LW, 32'h102, 32'h0, 32'h1122_3344, 0);
    run_access(OP_SH, 32'h301, 32'hAAAA_5555, 32'h0, 0);
    run_access(OP_LH, 32'h103, 32'h0, 32'h8001_7FFE, 1);
  endtask

  task automatic test_reset_in_wait();
    i_valid = 1'b1; i_lsu_op = OP_LW; i_addr = 32'h500;
    step();
    i_valid = 1'b0;
    #1;
    checks++;
    if (o_mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_req got=%b exp=1", o_mem_req);
    end
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    i_mem_ack = 1'b1;
    #1;
    checks++;
    if ({o_mem_req, o_done, o_stall} !== 3'b000) begin
      failures++;
      $display("FAIL rst_wait_drop got=%b%b%b exp=000",
               o_mem_req, o_done, o_stall);
    end
    step();
    i_mem_ack = 1'b0;
    checks++;
    if ({o_done, o_mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL rst_wait_nodone got=%b%b exp=00",
               o_done, o_mem_req);
    end
    run_access(OP_LW, 32'h504, 32'h0, 32'h0BAD_CAFE, 0);
  endtask

  task automatic test_ack_outside_wait();
    i_mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({o_done, o_mem_req, o_stall, o_timeout} !== 4'b0000) begin
        failures++;
        $display("FAIL stray_ack k=%0d got=%b%b%b%b exp=0000", k,
                 o_done, o_mem_req, o_stall, o_timeout);
      end
    end
    i_mem_ack = 1'b0;
  endtask

  task automatic test_noop();
    run_access(4'b0011, 32'h600, 32'h1, 32'h0, 0);
    run_access(4'b0110, 32'h601, 32'h2, 32'h0, 0);
    run_access(4'b1111, 32'h602, 32'h3, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [11];
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH,
            OP_SW, 4'b0011, 4'b0111, 4'b1110};
    for (int n = 0; n < 60; n++) begin
      run_access(ops[$urandom_range(0, 10)], $urandom, $urandom,
                 $urandom, int'($urandom_range(0, TMO - 1)));
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_loads();
    test_timeout();
    test_misalign();
    test_reset_in_wait();
    test_ack_outside_wait();
    test_noop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
